// File: rtl/aes_mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns over a 4x4 byte state, ColsPerCycle columns per edge.
// Define AES_MIXCOL_SEQ_CLEAR_EN to wipe the state buffer when the result is handed off.

package aes_pkg;
    typedef enum logic [1:0] {
        CIPH_FWD = 2'b00,
        CIPH_INV = 2'b01
    } ciph_op_e;
endpackage

module aes_mix_single_column (
    input  aes_pkg::ciph_op_e op_i,
    input  logic [3:0][7:0]   data_i,
    output logic [3:0][7:0]   data_o
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = b;
        for (int k = 0; k < 4; k++) begin
            if (c[k]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // One output row: coefficients rotate with the row, inputs are passed pre-rotated.
    function automatic logic [7:0] mix_row(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3,
                                           input logic inv);
        if (inv) return gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9);
        return gf_mul(a0, 4'd2) ^ gf_mul(a1, 4'd3) ^ a2 ^ a3;
    endfunction

    logic inv;
    assign inv = (op_i == aes_pkg::CIPH_INV);

    always_comb begin
        data_o[0] = mix_row(data_i[0], data_i[1], data_i[2], data_i[3], inv);
        data_o[1] = mix_row(data_i[1], data_i[2], data_i[3], data_i[0], inv);
        data_o[2] = mix_row(data_i[2], data_i[3], data_i[0], data_i[1], inv);
        data_o[3] = mix_row(data_i[3], data_i[0], data_i[1], data_i[2], inv);
    end
endmodule

module aes_mix_columns_seq #(
    parameter int ColsPerCycle = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  aes_pkg::ciph_op_e      op_i,
    input  logic [3:0][3:0][7:0]   data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [3:0][3:0][7:0]   data_o,
    input  logic                   abort_i,
    output logic                   err_o,
    output logic                   busy_o
);
    import aes_pkg::*;

    if (!(ColsPerCycle == 1 || ColsPerCycle == 2 || ColsPerCycle == 4)) begin : g_bad_cols
        $error("aes_mix_columns_seq: ColsPerCycle must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                          state_q, state_d;
    logic [1:0]                      cnt_q;
    logic [3:0][3:0][7:0]            data_q;
    ciph_op_e                        op_q;
    logic [ColsPerCycle-1:0][1:0]    col_idx;
    logic [ColsPerCycle-1:0][3:0][7:0] mix_in, mix_out;
    logic                            accept, op_ok_in, op_ok_q, last_step;

    always_comb begin
        for (int i = 0; i < ColsPerCycle; i++) begin
            col_idx[i] = 2'(int'(cnt_q) * ColsPerCycle + i);
            mix_in[i]  = data_q[col_idx[i]];
        end
    end

    for (genvar g = 0; g < ColsPerCycle; g++) begin : g_mix
        aes_mix_single_column u_mix (
            .op_i   (op_q),
            .data_i (mix_in[g]),
            .data_o (mix_out[g])
        );
    end

    assign last_step = (col_idx[ColsPerCycle-1] == 2'd3);
    assign accept    = (state_q == IDLE) && in_valid_i && !abort_i;
    assign op_ok_in  = (op_i == CIPH_FWD) || (op_i == CIPH_INV);
    assign op_ok_q   = (op_q == CIPH_FWD) || (op_q == CIPH_INV);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = op_ok_in ? BUSY : DONE;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Datapath: capture on accept, in-place column rewrite while busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 2'd0;
            data_q <= '0;
            op_q   <= CIPH_FWD;
        end else if (abort_i) begin
            cnt_q  <= 2'd0;
            data_q <= '0;
            op_q   <= CIPH_FWD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op_i;
                        cnt_q  <= 2'd0;
                        data_q <= op_ok_in ? data_i : '0;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < ColsPerCycle; i++) begin
                        data_q[col_idx[i]] <= mix_out[i];
                    end
                    cnt_q <= last_step ? 2'd0 : cnt_q + 2'd1;
                end
                DONE: begin
`ifdef AES_MIXCOL_SEQ_CLEAR_EN
                    if (out_ready_i) data_q <= '0;
`endif
                end
                default: cnt_q <= 2'd0;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign data_o      = out_valid_o ? data_q : '0;
    assign err_o       = out_valid_o && !op_ok_q;
endmodule
